// File: rtl/dmem_access_ctrl.sv
// MEM-stage load/store sequencer for a variable-latency req/ready data memory.
// Builds byte strobes, replicates store data, extends load data, stalls the pipe and flags bad accesses.
module dmem_access_ctrl #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  Funct3,
   input  logic [31:0] Addr,
   input  logic [31:0] WrData,
   output logic        Stall,
   output logic [31:0] RdData,
   output logic        Done,
   output logic        Err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic [31:0]      rd_q, rd_d;
   logic             req_q, req_d;
   logic             we_q, we_d;
   logic [31:0]      addr_q, addr_d;
   logic [3:0]       be_q, be_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [2:0]       f3_q, f3_d;
   logic [1:0]       off_q, off_d;
   logic             stall_c;

   logic             is_load, is_store, size_ok, aligned, access_ok, access_bad;
   logic [3:0]       be_c;
   logic [31:0]      wdata_c;

   // Extend the selected byte/half of the returned word according to the latched access size.
   function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] d);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (off)
         2'd0:    b = d[7:0];
         2'd1:    b = d[15:8];
         2'd2:    b = d[23:16];
         default: b = d[31:24];
      endcase
      h = off[1] ? d[31:16] : d[15:0];
      case (f3)
         3'b000:  r = {{24{b[7]}}, b};
         3'b001:  r = {{16{h[15]}}, h};
         3'b100:  r = {24'd0, b};
         3'b101:  r = {16'd0, h};
         default: r = d;
      endcase
      return r;
   endfunction

   // Classify the instruction currently presented by EX/MEM.
   always_comb begin
      is_load  = MemRead & ~MemWrite;
      is_store = MemWrite & ~MemRead;
      if (is_load)
         size_ok = Funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      else
         size_ok = Funct3 inside {3'b000, 3'b001, 3'b010};
      case (Funct3[1:0])
         2'b01:   aligned = ~Addr[0];
         2'b10:   aligned = (Addr[1:0] == 2'b00);
         default: aligned = 1'b1;
      endcase
      access_ok  = (is_load | is_store) & size_ok & aligned;
      access_bad = (MemRead & MemWrite) | ((is_load | is_store) & ~(size_ok & aligned));
      case (Funct3[1:0])
         2'b00:   begin be_c = 4'b0001 << Addr[1:0]; wdata_c = {4{WrData[7:0]}};  end
         2'b01:   begin be_c = 4'b0011 << Addr[1:0]; wdata_c = {2{WrData[15:0]}}; end
         default: begin be_c = 4'b1111;              wdata_c = WrData;             end
      endcase
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      rd_d    = rd_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      f3_d    = f3_q;
      off_d   = off_q;
      stall_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (access_ok) begin
               stall_c = 1'b1;
               req_d   = 1'b1;
               we_d    = is_store;
               addr_d  = {Addr[31:2], 2'b00};
               be_d    = be_c;
               wdata_d = is_store ? wdata_c : 32'd0;
               f3_d    = Funct3;
               off_d   = Addr[1:0];
               cnt_d   = '0;
               state_d = BUSY;
            end else if (access_bad) begin
               done_d  = 1'b1;
               err_d   = 1'b1;
               rd_d    = 32'd0;
               state_d = DONE;
            end
         end
         BUSY: begin
            stall_c = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
            // A ready on the last counted cycle still completes normally.
            if (mem_ready || (cnt_q == CNT_LAST)) begin
               done_d  = 1'b1;
               err_d   = ~mem_ready;
               rd_d    = (mem_ready && !we_q) ? load_ext(f3_q, off_q, mem_rdata) : 32'd0;
               req_d   = 1'b0;
               we_d    = 1'b0;
               addr_d  = 32'd0;
               be_d    = 4'd0;
               wdata_d = 32'd0;
               cnt_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rd_q    <= 32'd0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         be_q    <= 4'd0;
         wdata_q <= 32'd0;
         f3_q    <= 3'd0;
         off_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
         rd_q    <= rd_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         f3_q    <= f3_d;
         off_q   <= off_d;
      end
   end

   // Stall is the only combinational output; it must not assert while reset is held.
   assign Stall     = stall_c & rst_n;
   assign RdData    = rd_q;
   assign Done      = done_q;
   assign Err       = err_q;
   assign mem_req   = req_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_be    = be_q;
   assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: drives MEM-stage accesses and a scripted memory.
module tb_dmem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        MemRead, MemWrite;
   logic [2:0]  Funct3;
   logic [31:0] Addr, WrData;
   logic        Stall, Done, Err;
   logic [31:0] RdData;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic        mem_ready;

   int n_chk  = 0;
   int n_pass = 0;

   int          stall_cnt, busy_cnt, done_cnt;
   logic [31:0] cap_rd, cap_addr, cap_wdata;
   logic [3:0]  cap_be;
   logic        cap_err, cap_we;

   dmem_access_ctrl #(.TIMEOUT(16), .CNT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .Funct3    (Funct3),
      .Addr      (Addr),
      .WrData    (WrData),
      .Stall     (Stall),
      .RdData    (RdData),
      .Done      (Done),
      .Err       (Err),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_be    (mem_be),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one access; memory answers after wait_n low-ready BUSY cycles (negative = never).
   task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rdat, input int wait_n);
      stall_cnt = 0; busy_cnt = 0; done_cnt = 0;
      cap_rd = '0; cap_err = 1'b0; cap_addr = '0; cap_wdata = '0; cap_be = '0; cap_we = 1'b0;
      MemRead = rd; MemWrite = wr; Funct3 = f3; Addr = a; WrData = wd;
      mem_rdata = rdat; mem_ready = 1'b0;
      #1;
      for (int c = 0; c < 64; c++) begin
         if (Stall) stall_cnt++;
         if (Done) begin
            done_cnt++;
            cap_rd  = RdData;
            cap_err = Err;
            MemRead = 1'b0; MemWrite = 1'b0; mem_ready = 1'b0;
            tick();
            break;
         end
         if (mem_req) begin
            if (busy_cnt == 0) begin
               cap_addr = mem_addr; cap_be = mem_be; cap_wdata = mem_wdata; cap_we = mem_we;
            end
            mem_ready = (wait_n >= 0) && (busy_cnt == wait_n);
            busy_cnt++;
         end
         tick();
      end
      MemRead = 1'b0; MemWrite = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic expect_acc(input string tag, input int es, input int eb,
                             input logic [31:0] erd, input logic eerr);
      chk({tag, "_stall"}, 32'(stall_cnt), 32'(es));
      chk({tag, "_busy"},  32'(busy_cnt),  32'(eb));
      chk({tag, "_done"},  32'(done_cnt),  32'd1);
      chk({tag, "_rd"},    cap_rd,         erd);
      chk({tag, "_err"},   32'(cap_err),   32'(eerr));
      chk({tag, "_pulse"}, {30'd0, Done, Err}, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'd0;
      Addr = '0; WrData = '0; mem_rdata = '0; mem_ready = 1'b0;
      #12;
      chk("rst_ctl",   {28'd0, Stall, Done, Err, mem_req}, 32'd0);
      chk("rst_we_be", {27'd0, mem_we, mem_be}, 32'd0);
      chk("rst_rd",    RdData, 32'd0);
      chk("rst_addr",  mem_addr, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      rst_n = 1'b1;
      tick();
      chk("idle_stall", {31'd0, Stall}, 32'd0);

      // LW, memory answers on the third BUSY cycle
      access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2);
      expect_acc("lw", 4, 3, 32'hDEADBEEF, 1'b0);
      chk("lw_addr", cap_addr, 32'h100);
      chk("lw_be",   {28'd0, cap_be}, 32'hF);
      chk("lw_we",   {31'd0, cap_we}, 32'd0);

      // SB to lane 3, zero-wait memory
      access(1'b0, 1'b1, 3'b000, 32'h203, 32'h000000A5, 32'h0, 0);
      expect_acc("sb", 2, 1, 32'h0, 1'b0);
      chk("sb_addr",  cap_addr, 32'h200);
      chk("sb_be",    {28'd0, cap_be}, 32'h8);
      chk("sb_wdata", cap_wdata, 32'hA5A5A5A5);
      chk("sb_we",    {31'd0, cap_we}, 32'd1);

      // SH lane 2 and SW pass-through
      access(1'b0, 1'b1, 3'b001, 32'h402, 32'h1234BEEF, 32'h0, 1);
      expect_acc("sh", 3, 2, 32'h0, 1'b0);
      chk("sh_be",    {28'd0, cap_be}, 32'hC);
      chk("sh_wdata", cap_wdata, 32'hBEEFBEEF);
      access(1'b0, 1'b1, 3'b010, 32'h40C, 32'hCAFEF00D, 32'h0, 0);
      chk("sw_wdata", cap_wdata, 32'hCAFEF00D);
      chk("sw_be",    {28'd0, cap_be}, 32'hF);

      // Load extension
      access(1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 32'h00800000, 0);
      expect_acc("lb", 2, 1, 32'hFFFFFF80, 1'b0);
      chk("lb_be", {28'd0, cap_be}, 32'h4);
      access(1'b1, 1'b0, 3'b100, 32'h102, 32'h0, 32'h00800000, 0);
      chk("lbu_rd", cap_rd, 32'h00000080);
      access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80010000, 0);
      chk("lh_rd", cap_rd, 32'hFFFF8001);
      chk("lh_be", {28'd0, cap_be}, 32'hC);
      access(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h80010000, 0);
      chk("lhu_rd", cap_rd, 32'h00008001);
      access(1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 32'h00007F00, 0);
      chk("lb1_rd", cap_rd, 32'h0000007F);

      // Illegal / misaligned accesses: no request, Done+Err without stalling
      access(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0);
      expect_acc("lw_mis", 0, 0, 32'h0, 1'b1);
      access(1'b0, 1'b1, 3'b001, 32'h101, 32'h0, 32'h0, 0);
      expect_acc("sh_mis", 0, 0, 32'h0, 1'b1);
      access(1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 32'h0, 0);
      expect_acc("rw_both", 0, 0, 32'h0, 1'b1);
      access(1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 0);
      expect_acc("sbu_bad", 0, 0, 32'h0, 1'b1);

      // Timeout, preceded by a load so RdData is nonzero beforehand
      access(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 32'h11111111, 0);
      access(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 32'h22222222, -1);
      expect_acc("tmo", 17, 16, 32'h0, 1'b1);
      chk("tmo_idle", {30'd0, Stall, mem_req}, 32'd0);
      access(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 32'h33333333, 15);
      expect_acc("tmo_edge", 17, 16, 32'h33333333, 1'b0);

      // Asynchronous reset in the middle of BUSY, access still held afterwards
      MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; Addr = 32'h300;
      mem_rdata = 32'h12345678; mem_ready = 1'b0;
      repeat (3) tick();
      chk("mid_req", {31'd0, mem_req}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_req_stall", {30'd0, mem_req, Stall}, 32'd0);
      tick();
      rst_n = 1'b1;
      #1;
      chk("arst_idle", {30'd0, Stall, mem_req}, 32'h2);
      access(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h12345678, 0);
      expect_acc("restart", 2, 1, 32'h12345678, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
